sha1_msg_loader: RTL and testbench

Front-end sequencer for the SHA1 hash co-processor: the writer side of the shared DPSRAM message interface that `SHA1_hash` reads.
- On a request, it generates the standard test message: a seed word, then each following word is the previous word rotated left by 1.
- It writes the message word-by-word into DPSRAM over the port_A protocol, then pulses `start_hash` to the core.
- It waits for `done` and captures the 160-bit digest.
- It replaces the behavioural stimulus so message loading and hashing can run on hardware.

---
 rtl/sha1_pkg.sv | 26 ++
 rtl/sha1_word_gen.sv | 30 +++
 rtl/sha1_msg_loader.sv | 173 +++++++++++++++++
 tb/tb_sha1_msg_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sha1_pkg : shared SHA1 constants, digest width and loader state encoding
// Rev 1.0
// -----------------------------------------------------------------------------
package sha1_pkg;

  localparam int WORD_BYTES = 4;
  localparam int DIGEST_W   = 160;

  localparam logic [31:0] H0 = 32'h67452301;
  localparam logic [31:0] H1 = 32'hEFCDAB89;
  localparam logic [31:0] H2 = 32'h98BADCFE;
  localparam logic [31:0] H3 = 32'h10325476;
  localparam logic [31:0] H4 = 32'hC3D2E1F0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    KICK  = 3'd2,
    WAIT  = 3'd3,
    CAPT  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sha1_word_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sha1_word_gen : message word register, loaded with the seed, rotl-1 per advance
// Rev 1.0
// -----------------------------------------------------------------------------
module sha1_word_gen (
  input  logic        clk,
  input  logic        nreset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] word
);

  logic [31:0] r_word;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_word <= '0;
    end else if (load) begin
      r_word <= seed;
    end else if (advance) begin
      r_word <= {r_word[30:0], r_word[31]};
    end
  end

  assign word = r_word;

endmodule
`default_nettype wire

// File: rtl/sha1_msg_loader.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sha1_msg_loader : writes the test message into DPSRAM, kicks the SHA1 core
//                   and captures its digest. Rev 1.0
// -----------------------------------------------------------------------------
module sha1_msg_loader
  import sha1_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int START_CYCLES = 2
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                load,
  input  logic [31:0]         seed,
  input  logic [31:0]         message_addr,
  input  logic [31:0]         message_size,
  output logic                port_A_clk,
  output logic [ADDR_W-1:0]   port_A_addr,
  output logic [31:0]         port_A_data_in,
  output logic                port_A_we,
  output logic                start_hash,
  input  logic                done,
  input  logic [DIGEST_W-1:0] hash,
  output logic [DIGEST_W-1:0] digest,
  output logic                busy,
  output logic                digest_valid,
  output logic                addr_err
);

  localparam int                KCNT_W      = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [KCNT_W-1:0] c_KICK_LAST = KCNT_W'(START_CYCLES - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(WORD_BYTES);

  state_t              r_state, w_state_next;
  logic [30:0]         r_words_left, w_words_left_next;
  logic [KCNT_W-1:0]   r_kick_cnt, w_kick_cnt_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic                r_we, w_we_next;
  logic                r_start, w_start_next;
  logic                r_busy, w_busy_next;
  logic                r_valid, w_valid_next;
  logic                r_err, w_err_next;
  logic [DIGEST_W-1:0] r_digest;
  logic                w_accept, w_advance, w_capture;
  logic [30:0]         w_word_cnt;
  logic                w_unused;

  // 33-bit sum so that sizes near 2^32 still round up correctly
  assign w_word_cnt = 31'(({1'b0, message_size} + 33'd3) >> 2);
  assign w_unused   = &{1'b0, message_addr[31:ADDR_W]};

  always_comb begin
    w_state_next      = r_state;
    w_words_left_next = r_words_left;
    w_kick_cnt_next   = r_kick_cnt;
    w_addr_next       = r_addr;
    w_we_next         = 1'b0;
    w_start_next      = 1'b0;
    w_busy_next       = 1'b1;
    w_valid_next      = 1'b0;
    w_err_next        = 1'b0;
    w_accept          = 1'b0;
    w_advance         = 1'b0;
    w_capture         = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy_next = 1'b0;
        if (load) begin
          if (message_addr[1:0] != 2'b00) begin
            w_err_next = 1'b1;
          end else begin
            w_accept        = 1'b1;
            w_busy_next     = 1'b1;
            w_addr_next     = message_addr[ADDR_W-1:0];
            w_kick_cnt_next = '0;
            if (w_word_cnt == '0) begin
              w_state_next = KICK;
              w_start_next = 1'b1;
            end else begin
              w_state_next      = WRITE;
              w_we_next         = 1'b1;
              w_words_left_next = w_word_cnt - 31'd1;
            end
          end
        end
      end
      WRITE: begin
        if (r_words_left == '0) begin
          w_state_next    = KICK;
          w_start_next    = 1'b1;
          w_kick_cnt_next = '0;
        end else begin
          w_we_next         = 1'b1;
          w_advance         = 1'b1;
          w_addr_next       = r_addr + c_ADDR_STEP;
          w_words_left_next = r_words_left - 31'd1;
        end
      end
      KICK: begin
        if (r_kick_cnt == c_KICK_LAST) begin
          w_state_next = WAIT;
        end else begin
          w_start_next    = 1'b1;
          w_kick_cnt_next = r_kick_cnt + KCNT_W'(1);
        end
      end
      WAIT: begin
        if (done) begin
          w_state_next = CAPT;
          w_valid_next = 1'b1;
          w_capture    = 1'b1;
        end
      end
      CAPT: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end
      default: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state      <= IDLE;
      r_words_left <= '0;
      r_kick_cnt   <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      r_digest     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_words_left <= w_words_left_next;
      r_kick_cnt   <= w_kick_cnt_next;
      r_addr       <= w_addr_next;
      r_we         <= w_we_next;
      r_start      <= w_start_next;
      r_busy       <= w_busy_next;
      r_valid      <= w_valid_next;
      r_err        <= w_err_next;
      if (w_capture) begin
        r_digest <= hash;
      end
    end
  end

  sha1_word_gen u_word_gen (
    .clk     (clk),
    .nreset  (nreset),
    .load    (w_accept),
    .seed    (seed),
    .advance (w_advance),
    .word    (port_A_data_in)
  );

  assign port_A_clk   = clk;
  assign port_A_addr  = r_addr;
  assign port_A_we    = r_we;
  assign start_hash   = r_start;
  assign digest       = r_digest;
  assign busy         = r_busy;
  assign digest_valid = r_valid;
  assign addr_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sha1_msg_loader.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sha1_msg_loader : randomized self-checking bench with a cycle-level model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_sha1_msg_loader;
  import sha1_pkg::*;

  localparam int SC = 2;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         load = 1'b0;
  logic [31:0]  seed = '0;
  logic [31:0]  message_addr = '0;
  logic [31:0]  message_size = '0;
  logic         port_A_clk;
  logic [15:0]  port_A_addr;
  logic [31:0]  port_A_data_in;
  logic         port_A_we;
  logic         start_hash;
  logic         done = 1'b0;
  logic [159:0] hash = '0;
  logic [159:0] digest;
  logic         busy;
  logic         digest_valid;
  logic         addr_err;

  int           n_checks = 0;
  int           n_err = 0;
  logic [159:0] exp_digest = '0;
  logic [31:0]  obs_data [0:255];

  always #5 clk = ~clk;

  sha1_msg_loader #(.ADDR_W(16), .START_CYCLES(SC)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .load           (load),
    .seed           (seed),
    .message_addr   (message_addr),
    .message_size   (message_size),
    .port_A_clk     (port_A_clk),
    .port_A_addr    (port_A_addr),
    .port_A_data_in (port_A_data_in),
    .port_A_we      (port_A_we),
    .start_hash     (start_hash),
    .done           (done),
    .hash           (hash),
    .digest         (digest),
    .busy           (busy),
    .digest_valid   (digest_valid),
    .addr_err       (addr_err)
  );

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl_ref(input logic [31:0] x, input int k);
    int s;
    s = k % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] rand_hash();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},     160'(port_A_we), 160'(0));
    check({tag, "_addr"},   160'(port_A_addr), 160'(0));
    check({tag, "_data"},   160'(port_A_data_in), 160'(0));
    check({tag, "_start"},  160'(start_hash), 160'(0));
    check({tag, "_busy"},   160'(busy), 160'(0));
    check({tag, "_valid"},  160'(digest_valid), 160'(0));
    check({tag, "_err"},    160'(addr_err), 160'(0));
    check({tag, "_digest"}, digest, 160'(0));
  endtask

  task automatic drive_junk();
    load         = 1'($urandom);
    seed         = $urandom;
    message_addr = $urandom;
    message_size = $urandom_range(0, 64);
  endtask

  // One request end to end; abort_at >= 0 resets the block while word abort_at is presented
  task automatic run_txn(input logic [31:0] s, input logic [31:0] a, input logic [31:0] sz,
                         input int abort_at, input int dly, input logic [159:0] h);
    longint      n;
    logic [15:0] ea;
    n = longint'(({32'b0, sz} + 64'd3) >> 2);
    load = 1'b1; seed = s; message_addr = a; message_size = sz;
    tick();
    load = 1'b0;
    if (a[1:0] != 2'b00) begin
      check("err_pulse", 160'(addr_err), 160'(1));
      check("err_busy",  160'(busy), 160'(0));
      check("err_we",    160'(port_A_we), 160'(0));
      tick();
      check("err_clear", 160'(addr_err), 160'(0));
      check("err_busy2", 160'(busy), 160'(0));
      check("err_start", 160'(start_hash), 160'(0));
      check("err_we2",   160'(port_A_we), 160'(0));
      return;
    end
    for (longint j = 0; j < n + SC; j++) begin
      check("busy",        160'(busy), 160'(1));
      check("we",          160'(port_A_we), 160'(j < n));
      check("start",       160'(start_hash), 160'(j >= n));
      check("valid",       160'(digest_valid), 160'(0));
      check("err_ignored", 160'(addr_err), 160'(0));
      check("digest_hold", digest, exp_digest);
      if (j < n) begin
        ea = a[15:0] + 16'(j * 4);
        check("addr", 160'(port_A_addr), 160'(ea));
        check("data", 160'(port_A_data_in), 160'(rotl_ref(s, int'(j % 32))));
        if (j < 256) obs_data[j] = port_A_data_in;
      end
      if (j == longint'(abort_at)) begin
        nreset = 1'b0; load = 1'b0; done = 1'b0;
        tick();
        check_reset_outputs("mid_rst");
        nreset = 1'b1;
        exp_digest = '0;
        return;
      end
      drive_junk();
      done = 1'($urandom);
      tick();
    end
    for (int w = 0; w <= dly; w++) begin
      check("wait_busy",  160'(busy), 160'(1));
      check("wait_we",    160'(port_A_we), 160'(0));
      check("wait_start", 160'(start_hash), 160'(0));
      check("wait_valid", 160'(digest_valid), 160'(0));
      if (w == dly) begin
        done = 1'b1; hash = h;
      end else begin
        done = 1'b0; hash = rand_hash();
      end
      drive_junk();
      tick();
    end
    done = 1'b0; hash = rand_hash(); load = 1'b0;
    exp_digest = h;
    check("valid_pulse", 160'(digest_valid), 160'(1));
    check("digest",      digest, h);
    check("capt_busy",   160'(busy), 160'(1));
    tick();
    check("valid_once",  160'(digest_valid), 160'(0));
    check("digest_keep", digest, h);
    check("idle_busy",   160'(busy), 160'(0));
    check("idle_we",     160'(port_A_we), 160'(0));
    check("idle_start",  160'(start_hash), 160'(0));
  endtask

  initial begin
    logic [31:0] rs, ra, rsz;
    nreset = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    nreset = 1'b1;
    tick();

    run_txn(32'h01234567, 32'h0, 32'd4, -1, 2, {128'h0123456789ABCDEF0011223344556677, 32'hDEADBEEF});
    check("t1_word0", 160'(obs_data[0]), 160'(32'h01234567));

    run_txn(32'h01234567, 32'h0, 32'd511, -1, 0, rand_hash());
    check("t2_word1",   160'(obs_data[1]), 160'(32'h02468ACE));
    check("t2_word127", 160'(obs_data[127]), 160'(32'h8091A2B3));

    run_txn(32'hCAFEF00D, 32'h00000100, 32'd0, -1, 3, rand_hash());

    run_txn(32'hA5A50001, 32'h0000FFFC, 32'd8, -1, 1, rand_hash());
    check("wrap_w0", 160'(obs_data[0]), 160'(32'hA5A50001));
    check("wrap_w1", 160'(obs_data[1]), 160'(32'h4B4A0003));

    run_txn(32'h11112222, 32'h00000002, 32'd16, -1, 0, rand_hash());

    run_txn(32'h89ABCDEF, 32'h00000040, 32'd64, 5, 0, rand_hash());
    run_txn(32'h89ABCDEF, 32'h00000040, 32'd64, -1, 1, rand_hash());
    check("restart_w0", 160'(obs_data[0]), 160'(32'h89ABCDEF));

    for (int t = 0; t < 20; t++) begin
      rs  = $urandom;
      ra  = $urandom;
      rsz = $urandom_range(0, 300);
      if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) ra[15:0] = 16'hFFF0 | (ra[15:0] & 16'h000C);
      run_txn(rs, ra, rsz, -1, $urandom_range(0, 4), rand_hash());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
